// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: three-digit, time-multiplexed common-anode 7-segment driver.
// Digits are double-buffered (shadow -> active) and swapped only on frame
// boundaries. Each digit slot opens with a guard window where everything is
// dark, then lights one digit. Optional leading-zero suppression is applied
// live from blank_lz.

// Per-digit segment decoder: code -> {g,f,e,d,c,b,a}, active-high.
// A = dash, B..F = blank. suppress forces the digit dark.
module seg7_digit_decode (
  input  logic [3:0] code,
  input  logic       suppress,
  output logic [6:0] seg
);

  // Combinational table lookup; suppression overrides the table.
  always_comb begin
    seg = 7'h00;
    if (!suppress) begin
      case (code)
        4'h0:    seg = 7'h3F;
        4'h1:    seg = 7'h06;
        4'h2:    seg = 7'h5B;
        4'h3:    seg = 7'h4F;
        4'h4:    seg = 7'h66;
        4'h5:    seg = 7'h6D;
        4'h6:    seg = 7'h7D;
        4'h7:    seg = 7'h07;
        4'h8:    seg = 7'h7F;
        4'h9:    seg = 7'h6F;
        4'hA:    seg = 7'h40;
        default: seg = 7'h00;
      endcase
    end
  end

endmodule

module seg7_scan_driver #(
  parameter int SCAN_DIV   = 50000,
  parameter int GUARD      = 4,
  parameter int ACTIVE_LOW = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic       blank_lz,
  output logic [6:0] segments,
  output logic [2:0] digit_en,
  output logic       frame_done
);

  localparam int NUM_DIGITS = 3;
  localparam int PRE_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic POL      = (ACTIVE_LOW != 0);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(SCAN_DIV - 1);
  localparam logic [PRE_W-1:0] GUARD_END = PRE_W'(GUARD);
  localparam logic [3:0] BLANK = 4'hB;

  // Digit index 0 = ones, 1 = tens, 2 = hundreds (matches digit_en bits).
  logic [NUM_DIGITS-1:0][3:0] load_digits;
  logic [NUM_DIGITS-1:0][3:0] shadow;
  logic [NUM_DIGITS-1:0][3:0] active;
  logic                       pending;

  logic [PRE_W-1:0] pre;
  logic [1:0]       idx;
  logic             term;
  logic             boundary;
  logic             in_guard;

  logic [NUM_DIGITS-1:0]      suppress;
  logic [NUM_DIGITS-1:0][6:0] dec_seg;
  logic [6:0]                 seg_nxt;
  logic [2:0]                 en_nxt;

  assign load_digits = {hundreds, tens, ones};

  assign term     = (pre == PRE_LAST);
  assign boundary = term && (idx == 2'd2);
  assign in_guard = (pre < GUARD_END);

  // Leading-zero blanking works on what is being displayed, not on the
  // shadow copy; ones always shows so a value of zero still reads "0".
  assign suppress[0] = 1'b0;
  assign suppress[1] = blank_lz && (active[2] == 4'h0) && (active[1] == 4'h0);
  assign suppress[2] = blank_lz && (active[2] == 4'h0);

  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_dec
      seg7_digit_decode u_dec (
        .code     (active[g]),
        .suppress (suppress[g]),
        .seg      (dec_seg[g])
      );
    end
  endgenerate

  // Prescaler and slot index; idx steps once per SCAN_DIV cycles, 0..2.
  always_ff @(posedge clock) begin
    if (reset) begin
      pre <= '0;
      idx <= 2'd0;
    end else if (term) begin
      pre <= '0;
      idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

  // Double buffer: loads go to shadow; active only changes at a frame
  // boundary. A load landing on the boundary bypasses shadow so it is
  // not held back a whole frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      shadow  <= {NUM_DIGITS{BLANK}};
      active  <= {NUM_DIGITS{BLANK}};
      pending <= 1'b0;
    end else begin
      if (load)
        shadow <= load_digits;
      if (boundary) begin
        pending <= 1'b0;
        if (load)
          active <= load_digits;
        else if (pending)
          active <= shadow;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  // Next-cycle slot drive, active-high: dark during guard, else one digit.
  always_comb begin
    seg_nxt = 7'h00;
    en_nxt  = 3'b000;
    if (!in_guard) begin
      case (idx)
        2'd0: begin en_nxt = 3'b001; seg_nxt = dec_seg[0]; end
        2'd1: begin en_nxt = 3'b010; seg_nxt = dec_seg[1]; end
        2'd2: begin en_nxt = 3'b100; seg_nxt = dec_seg[2]; end
        default: begin en_nxt = 3'b000; seg_nxt = 7'h00; end
      endcase
    end
  end

  // Output registers; polarity is applied only here.
  always_ff @(posedge clock) begin
    if (reset) begin
      segments   <= {7{POL}};
      digit_en   <= {3{POL}};
      frame_done <= 1'b0;
    end else begin
      segments   <= seg_nxt ^ {7{POL}};
      digit_en   <= en_nxt ^ {3{POL}};
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (SCAN_DIV=8, GUARD=2, active-low).
// Stimulus loads digits and queues the expected {digit_en,segments} of each
// lit slot of the frame that will show them; a negedge monitor pops one entry
// per lit slot and also checks guard darkness, guard length and slot length.
module tb_seg7_scan_driver;

  localparam int SCAN_DIV = 8;
  localparam int GUARD    = 2;
  localparam int FRAME    = 3 * SCAN_DIV;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [3:0] hundreds = 4'h0;
  logic [3:0] tens = 4'h0;
  logic [3:0] ones = 4'h0;
  logic       blank_lz = 1'b0;
  logic [6:0] segments;
  logic [2:0] digit_en;
  logic       frame_done;

  always #5 clock = ~clock;

  seg7_scan_driver #(
    .SCAN_DIV   (SCAN_DIV),
    .GUARD      (GUARD),
    .ACTIVE_LOW (1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .hundreds   (hundreds),
    .tens       (tens),
    .ones       (ones),
    .blank_lz   (blank_lz),
    .segments   (segments),
    .digit_en   (digit_en),
    .frame_done (frame_done)
  );

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];
  bit mon_en = 1'b0;
  int fcyc = 0;

  typedef struct {
    bit          pre_en;
    logic [11:0] pre_v;
    bit          ld;
    bit          bnd;
    logic [11:0] v;
    bit          lz;
    logic [6:0]  e0, e1, e2;
  } row_t;

  row_t rows[11];

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // ---------------- monitor ----------------
  bit         in_lit = 1'b0;
  bit         first_slot = 1'b1;
  bit         changed = 1'b0;
  int         off_run = 0;
  int         lit_len = 0;
  logic [9:0] cur;
  logic [9:0] want;

  always @(negedge clock) begin
    if (!mon_en) begin
      in_lit     = 1'b0;
      first_slot = 1'b1;
      off_run    = 0;
    end else if (digit_en == 3'b111) begin
      chk("guard_segments", segments, 7'h7F);
      if (in_lit) begin
        chk("slot_length", lit_len, SCAN_DIV - GUARD);
        chk("slot_stable", changed, 0);
        in_lit  = 1'b0;
        off_run = 0;
      end
      off_run++;
    end else if (!in_lit) begin
      if (!first_slot) chk("guard_length", off_run, GUARD);
      first_slot = 1'b0;
      in_lit     = 1'b1;
      lit_len    = 1;
      changed    = 1'b0;
      cur        = {digit_en, segments};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL slot_unexpected: got en=%b seg=%h expected no lit slot",
                 digit_en, segments);
      end else begin
        want = exp_q.pop_front();
        if (cur != want) begin
          errors++;
          $display("FAIL slot_value: got en=%b seg=%h expected en=%b seg=%h",
                   cur[9:7], cur[6:0], want[9:7], want[6:0]);
        end
      end
    end else begin
      lit_len++;
      if ({digit_en, segments} != cur) changed = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clock);
    fcyc++;
  endtask

  task automatic goto_cyc(input int n);
    while (fcyc < n) step();
  endtask

  task automatic pulse_load(input logic [11:0] v);
    {hundreds, tens, ones} = v;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic push_frame(input logic [6:0] e0, input logic [6:0] e1,
                            input logic [6:0] e2);
    exp_q.push_back({3'b110, e0});
    exp_q.push_back({3'b101, e1});
    exp_q.push_back({3'b011, e2});
  endtask

  // Wait for frame_done (bounded) and check it arrived exactly one frame on.
  task automatic wait_frame();
    int n = 0;
    while (!frame_done && n < 2 * FRAME) begin
      step();
      n++;
    end
    chk("frame_done_seen", frame_done, 1);
    chk("frame_period", fcyc, FRAME);
    fcyc = 0;
  endtask

  function automatic row_t mk(input bit pre_en, input logic [11:0] pre_v,
                              input bit ld, input bit bnd, input logic [11:0] v,
                              input bit lz, input logic [6:0] e0,
                              input logic [6:0] e1, input logic [6:0] e2);
    row_t r;
    r.pre_en = pre_en; r.pre_v = pre_v; r.ld = ld; r.bnd = bnd; r.v = v;
    r.lz = lz; r.e0 = e0; r.e1 = e1; r.e2 = e2;
    return r;
  endfunction

  initial begin
    row_t r;
    //            pre  pre_v    ld bnd v        lz  ones   tens   hund
    rows[0]  = mk(0, 12'h000, 1, 0, 12'h123, 0, 7'h30, 7'h24, 7'h79);
    rows[1]  = mk(0, 12'h000, 1, 0, 12'h007, 1, 7'h78, 7'h7F, 7'h7F);
    rows[2]  = mk(0, 12'h000, 1, 0, 12'h000, 1, 7'h40, 7'h7F, 7'h7F);
    rows[3]  = mk(0, 12'h000, 1, 0, 12'h050, 1, 7'h40, 7'h12, 7'h7F);
    rows[4]  = mk(0, 12'h000, 1, 0, 12'hAAA, 1, 7'h3F, 7'h3F, 7'h3F);
    rows[5]  = mk(0, 12'h000, 1, 0, 12'hBBB, 0, 7'h7F, 7'h7F, 7'h7F);
    rows[6]  = mk(1, 12'h444, 1, 0, 12'h999, 0, 7'h10, 7'h10, 7'h10);
    rows[7]  = mk(0, 12'h000, 1, 0, 12'h004, 0, 7'h19, 7'h40, 7'h40);
    rows[8]  = mk(0, 12'h000, 0, 0, 12'h000, 1, 7'h19, 7'h7F, 7'h7F);
    rows[9]  = mk(1, 12'h222, 1, 1, 12'h860, 1, 7'h40, 7'h02, 7'h00);
    rows[10] = mk(0, 12'h000, 0, 0, 12'h000, 0, 7'h40, 7'h02, 7'h00);

    // Reset held for three edges.
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("reset_segments", segments, 7'h7F);
    chk("reset_digit_en", digit_en, 3'b111);
    chk("reset_frame_done", frame_done, 0);

    reset  = 1'b0;
    fcyc   = 0;
    mon_en = 1'b1;
    push_frame(7'h7F, 7'h7F, 7'h7F);

    // Each row is loaded in one frame and displayed in the next.
    for (int i = 0; i < 11; i++) begin
      r = rows[i];
      if (r.pre_en) begin
        goto_cyc(3);
        pulse_load(r.pre_v);
      end
      if (r.ld) begin
        goto_cyc(r.bnd ? FRAME - 1 : 6);
        pulse_load(r.v);
      end else begin
        goto_cyc(6);
      end
      push_frame(r.e0, r.e1, r.e2);
      wait_frame();
      blank_lz = r.lz;
    end

    // Let the last queued frame play out.
    step();
    wait_frame();
    step();
    step();
    chk("queue_drained", exp_q.size(), 0);
    mon_en = 1'b0;

    // Reset in the middle of the tens slot, with a load on the same cycle.
    goto_cyc(12);
    chk("pre_reset_tens_lit", digit_en, 3'b101);
    reset = 1'b1;
    pulse_load(12'h777);
    chk("midreset_segments", segments, 7'h7F);
    chk("midreset_digit_en", digit_en, 3'b111);
    chk("midreset_frame_done", frame_done, 0);
    step();
    step();
    reset    = 1'b0;
    blank_lz = 1'b0;
    fcyc     = 0;
    mon_en   = 1'b1;
    push_frame(7'h7F, 7'h7F, 7'h7F);
    push_frame(7'h7F, 7'h7F, 7'h7F);
    wait_frame();
    step();
    wait_frame();
    step();
    step();
    chk("post_reset_drained", exp_q.size(), 0);
    mon_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Registered, time-multiplexed driver for a three-digit common-anode seven-segment display. It sits directly downstream of the binary-to-BCD converter and takes its Hundreds/Tens/Ones nibbles, including the dash code 4'hA and blank code 4'hB. It double-buffers the digits and changes them only on frame boundaries to avoid tearing. It scans one digit at a time, with a guard interval between digits, and performs optional leading-zero suppression.

## Interface
- SCAN_DIV, 50000: clock cycles per digit slot; legal range ≥ 4.
- GUARD, 4: cycles at the start of each slot with all digits off (anti-ghosting); legal range 1 ≤ GUARD < SCAN_DIV.
- ACTIVE_LOW, 1: 1 = segment and digit-enable outputs are active-low; 0 = active-high.
- clock  input  1  single system clock, rising edge.
- reset  input  1  synchronous, active-high.
- load  input  1  one-cycle strobe; capture hundreds/tens/ones.
- hundreds  input  4  BCD digit or code (A = dash, B = blank).
- tens  input  4  as above.
- ones  input  4  as above.
- blank_lz  input  1  level; 1 = suppress leading zeros.
- segments  output  7  bit0 = a … bit6 = g, polarity per ACTIVE_LOW.
- digit_en  output  3  bit0 = ones, bit1 = tens, bit2 = hundreds; polarity per ACTIVE_LOW.
- frame_done  output  1  one-cycle pulse at each frame boundary.

## Operation
- Storage:
  - shadow[3] holds the most recently loaded digits.
  - active[3] holds the digits currently displayed.
  - pending flag marks that shadow holds data not yet shown.
- load: shadow <= inputs, pending <= 1. Multiple loads within one frame: the last one wins.
- Prescaler `pre` counts 0..SCAN_DIV-1 and wraps. At the terminal count, slot index `idx` advances 0→1→2→0.
- Frame boundary is the cycle where pre == SCAN_DIV-1 and idx == 2. On that cycle:
  - frame_done pulses.
  - If pending, active <= shadow and pending <= 0.
  - If load is also high on that cycle, active takes the port values directly and pending ends at 0.
- Digit decode, active-high internally, hex {g..a}:
  - 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07, 8 = 7F, 9 = 6F.
  - A (dash) = 40.
  - B–F = 00 (blank).
- Leading-zero suppression applies when blank_lz = 1:
  - Hundreds blanks if active hundreds == 0.
  - Tens blanks if active hundreds == 0 and active tens == 0.
  - Ones is never suppressed.
  - blank_lz is sampled live, not buffered.
- Slot output:
  - While pre < GUARD, digit_en is all off and segments are all off.
  - Otherwise, exactly one digit_en bit (for idx) is on, and segments shows the decode of active[idx].
- ACTIVE_LOW = 1 inverts segments and digit_en at the output registers only.

## Timing
- segments, digit_en and frame_done are registered. They reflect the pre/idx/active state of the preceding cycle, so the output latency is 1 cycle.
- Reset values:
  - Counters and control: pre = 0, idx = 0, pending = 0.
  - Digit registers: active = shadow = B,B,B.
  - Outputs: frame_done = 0; segments all off (7'h7F when ACTIVE_LOW = 1); digit_en all off (3'b111 when ACTIVE_LOW = 1).
- Reset asserted mid-scan forces all reset values on the next edge. It overrides load and any frame boundary in the same cycle.
- Frame length is 3·SCAN_DIV cycles. frame_done period is exactly 3·SCAN_DIV.
- Load-to-visible latency is at most 3·SCAN_DIV + 1 cycles and at least 1 cycle (load on a boundary cycle).
- With a stable pre/idx sequence, each digit is lit for SCAN_DIV−GUARD cycles per frame.
- The first frame_done after reset occurs 3·SCAN_DIV cycles after reset deasserts. The register output follows 1 cycle later.
- Duty per digit is (SCAN_DIV−GUARD)/(3·SCAN_DIV). There is no dependency on the input values.

## Test plan
- Bench parameters: SCAN_DIV = 8, GUARD = 2, ACTIVE_LOW = 1.
- Reset: hold reset 3 cycles, then release → segments = 7'h7F and digit_en = 3'b111 until the first lit slot. That first slot lights ones with segments = 7'h7F (blank). frame_done first pulses 24 cycles after release.
- Load 1,2,3 with blank_lz = 0, mid-frame → the old value persists until the boundary. Next frame, per digit (digit_en → segments):
  - 3'b110 → 7'h30
  - 3'b101 → 7'h24
  - 3'b011 → 7'h79
  - The guard cycles show 3'b111 / 7'h7F.
- Leading zeros with blank_lz = 1:
  - Load 0,0,7 → hundreds and tens slots show 7'h7F, ones shows 7'h78.
  - Load 0,0,0 → ones shows 7'h40.
  - Load 0,5,0 → tens shows 7'h12, hundreds blank.
- Codes: load A,A,A → all slots show 7'h3F. Load B,B,B → all slots show 7'h7F.
- Simultaneous events:
  - Two loads in one frame (4,4,4 then 9,9,9) → only 9s appear (7'h10).
  - A load on the boundary cycle → visible in the next slot with no extra frame of delay.
- Reset mid-scan with idx = 1 and digits loaded → the next cycle shows all reset values. The displayed digits are blank until a new load.
